// File: rtl/seq_multiplier.sv
// Multi-cycle shift-add multiplier for the RV32 MUL instruction.
// Returns the low WIDTH bits of rs1_data*rs2_data after exactly WIDTH busy cycles.
module seq_multiplier #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] rs1_data,
    input  logic [WIDTH-1:0] rs2_data,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q;
    logic               busy_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]   result_q;
    logic [CNT_W-1:0]   count_q;
    logic [WIDTH-1:0]   acc_d;

    // One shift-add step; the carry out of the top bit is discarded.
    always_comb begin
        acc_d = acc_q;
        if (b_q[0]) begin
            acc_d = acc_q + a_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            count_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= rs1_data;
                        b_q     <= rs2_data;
                        acc_q   <= '0;
                        count_q <= CNT_W'(WIDTH);
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    // start is deliberately ignored here, including on the completion edge
                    acc_q   <= acc_d;
                    a_q     <= a_q << 1;
                    b_q     <= b_q >> 1;
                    count_q <= count_q - CNT_W'(1);
                    if (count_q == CNT_W'(1)) begin
                        result_q <= acc_d;
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign result = result_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: latency, arithmetic corners, ignored starts, reset abort.
module tb_seq_multiplier;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] result;
    logic        busy;

    int compared;
    int mismatched;
    int cycles;

    seq_multiplier #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .result   (result),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Single run with operands scrambled after E0; checks hold, latency and product.
    task automatic do_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input logic [31:0] prev);
        int n;
        @(negedge clk);
        rs1_data = a;
        rs2_data = b;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        rs1_data = $urandom;
        rs2_data = $urandom;
        n = 0;
        while (busy && n < 100) begin
            n++;
            if (n == 16) check({tag, "_hold"}, result, prev);
            @(negedge clk);
        end
        check({tag, "_lat"}, 32'(n), 32'd32);
        check(tag, result, exp);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b1;
        start      = 1'b0;
        rs1_data   = '0;
        rs2_data   = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_result", result, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        do_mul("3x5",       32'd3,          32'd5,          32'h0000000F, 32'h0);
        do_mul("min_x2",    32'h80000000,   32'd2,          32'h00000000, 32'h0000000F);
        do_mul("ones_sq",   32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000001, 32'h0);
        do_mul("zero_x",    32'h0,          32'h12345678,   32'h00000000, 32'h00000001);
        do_mul("hi_sq",     32'h00010000,   32'h00010000,   32'h00000000, 32'h0);
        do_mul("neg7x6",    32'hFFFFFFF9,   32'h00000006,   32'hFFFFFFD6, 32'h0);

        // 7*9 with starts during the run and on the completion edge, then back-to-back 6*7
        @(negedge clk);
        rs1_data = 32'd7;
        rs2_data = 32'd9;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        rs1_data = 32'd2;
        rs2_data = 32'd2;
        cycles   = 0;
        while (busy && cycles < 100) begin
            cycles++;
            if (cycles == 10) check("7x9_hold", result, 32'hFFFFFFD6);
            if (cycles == 5 || cycles == 32) begin
                start    = 1'b1;
                rs1_data = (cycles == 5) ? 32'd2 : 32'd4;
                rs2_data = (cycles == 5) ? 32'd2 : 32'd4;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        check("7x9_lat", 32'(cycles), 32'd32);
        check("7x9", result, 32'd63);
        check("cmpl_start_ignored", {31'd0, busy}, 32'd0);
        rs1_data = 32'd6;
        rs2_data = 32'd7;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy", {31'd0, busy}, 32'd1);
        check("b2b_hold", result, 32'd63);
        cycles = 1;
        @(negedge clk);
        while (busy && cycles < 100) begin
            cycles++;
            @(negedge clk);
        end
        check("b2b_lat", 32'(cycles), 32'd32);
        check("6x7", result, 32'd42);

        // Asynchronous reset mid-run aborts and clears result
        rs1_data = 32'd7;
        rs2_data = 32'd9;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        check("async_rst_result", result, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_idle", {31'd0, busy}, 32'd0);
        do_mul("4x4", 32'd4, 32'd4, 32'd16, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
